// File: rtl/tdm_mux_8to1_if.sv
// Stream bundle of the 8-to-1 TDM multiplexer: parallel channels and frame
// request in, slot-serial beats with ready/valid handshake out.
interface tdm_mux_8to1_if #(
  parameter int WIDTH = 1
);
  logic [8*WIDTH-1:0] din;
  logic               start;
  logic               out_ready;
  logic [WIDTH-1:0]   y;
  logic [2:0]         sel;
  logic               out_valid;
  logic               frame_start;
  logic               busy;
  logic               done;

  // master is the multiplexer itself, slave is the producer/consumer side
  modport master (
    input  din, start, out_ready,
    output y, sel, out_valid, frame_start, busy, done
  );

  modport slave (
    output din, start, out_ready,
    input  y, sel, out_valid, frame_start, busy, done
  );
endinterface

// File: rtl/tdm_mux_8to1.sv
// Time-division 8-to-1 multiplexer: snapshots eight channels on a start
// request and streams them one slot per accepted beat, with slot index.
module tdm_mux_8to1 #(
  parameter int WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tdm_mux_8to1_if.master       bus
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] din_ch   [8];
  logic [WIDTH-1:0] snap_reg [8];
  logic [WIDTH-1:0] y_reg;
  logic [2:0]       sel_reg;
  logic             out_valid_reg;
  logic             frame_start_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [2:0]       sel_inc;
  logic             last_slot;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_ch
      assign din_ch[gi] = bus.din[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign sel_inc   = sel_reg + 3'd1;
  assign last_slot = (sel_reg == 3'd7);

  // y is always loaded with the value the next sel points at, so y tracks
  // snapshot[sel] without any combinational mux on the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      y_reg           <= '0;
      sel_reg         <= 3'd0;
      out_valid_reg   <= 1'b0;
      frame_start_reg <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        snap_reg[i] <= '0;
      end
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            for (int i = 0; i < 8; i++) begin
              snap_reg[i] <= din_ch[i];
            end
            y_reg           <= din_ch[0];
            sel_reg         <= 3'd0;
            out_valid_reg   <= 1'b1;
            frame_start_reg <= 1'b1;
            busy_reg        <= 1'b1;
            state_reg       <= SEND;
          end
        end

        SEND: begin
          if (out_valid_reg && bus.out_ready) begin
            if (!last_slot) begin
              sel_reg         <= sel_inc;
              y_reg           <= snap_reg[sel_inc];
              frame_start_reg <= 1'b0;
            end else if (bus.start) begin
              // back-to-back frame: recapture with no idle bubble
              for (int i = 0; i < 8; i++) begin
                snap_reg[i] <= din_ch[i];
              end
              y_reg           <= din_ch[0];
              sel_reg         <= 3'd0;
              frame_start_reg <= 1'b1;
            end else begin
              y_reg           <= snap_reg[0];
              sel_reg         <= 3'd0;
              out_valid_reg   <= 1'b0;
              frame_start_reg <= 1'b0;
              busy_reg        <= 1'b0;
              done_reg        <= 1'b1;
              state_reg       <= IDLE;
            end
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.y           = y_reg;
  assign bus.sel         = sel_reg;
  assign bus.out_valid   = out_valid_reg;
  assign bus.frame_start = frame_start_reg;
  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;

endmodule

// File: tb/tb_tdm_mux_8to1.sv
// Directed bench for tdm_mux_8to1: a WIDTH=1 vector table plus WIDTH=4
// hand sequences for stall, snapshot, back-to-back, late start, loopback, reset.
module tb_tdm_mux_8to1;

  logic clk;
  logic rst_n;

  tdm_mux_8to1_if #(.WIDTH(1)) bus1 ();
  tdm_mux_8to1_if #(.WIDTH(4)) bus4 ();

  tdm_mux_8to1 #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  tdm_mux_8to1 #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       start;
    logic       rdy;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [10];

  // receiving 1-to-8 demultiplexer for the loopback check
  logic       dmx_clr;
  logic [3:0] dmx_q [8];
  always @(posedge clk) begin
    if (dmx_clr) begin
      for (int i = 0; i < 8; i++) dmx_q[i] <= 4'h0;
    end else if (bus4.out_valid && bus4.out_ready) begin
      dmx_q[bus4.sel] <= bus4.y;
    end
  end

  function automatic logic [7:0] pk1(input int v, input int s, input int yv,
                                     input int fs, input int b, input int d);
    return {v[0], 3'(s), yv[0], fs[0], b[0], d[0]};
  endfunction

  function automatic logic [10:0] pk4(input int v, input int s, input int yv,
                                      input int fs, input int b, input int d);
    return {v[0], 3'(s), 4'(yv), fs[0], b[0], d[0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // packed {out_valid, sel, y, frame_start, busy, done} of the WIDTH=4 instance
  task automatic chk4(input string name, input int v, input int s, input int yv,
                      input int fs, input int b, input int d);
    chk(name, 32'({bus4.out_valid, bus4.sel, bus4.y, bus4.frame_start, bus4.busy, bus4.done}),
        32'(pk4(v, s, yv, fs, b, d)));
  endtask

  task automatic drive4(input logic s, input logic r);
    bus4.start     = s;
    bus4.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic s, input logic r);
    bus1.start     = s;
    bus1.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  din1;
    logic [31:0] dl;
    int          seen;

    rst_n          = 1'b0;
    dmx_clr        = 1'b1;
    bus1.din       = '0;
    bus1.start     = 1'b0;
    bus1.out_ready = 1'b0;
    bus4.din       = '0;
    bus4.start     = 1'b0;
    bus4.out_ready = 1'b0;
    #22;
    chk4("reset_w4", 0, 0, 0, 0, 0, 0);
    chk("reset_w1", 32'({bus1.out_valid, bus1.sel, bus1.y, bus1.frame_start, bus1.busy, bus1.done}), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single frame, WIDTH=1, table driven
    din1     = 8'b1010_0110;
    bus1.din = din1;
    tbl[0] = '{1'b1, 1'b1, pk1(1, 0, 0, 1, 1, 0)};
    for (int s = 1; s < 8; s++) tbl[s] = '{1'b0, 1'b1, pk1(1, s, int'(din1[s]), 0, 1, 0)};
    tbl[8] = '{1'b0, 1'b1, pk1(0, 0, 0, 0, 0, 1)};
    tbl[9] = '{1'b0, 1'b1, pk1(0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 10; i++) begin
      drive1(tbl[i].start, tbl[i].rdy);
      chk($sformatf("w1_row%0d", i),
          32'({bus1.out_valid, bus1.sel, bus1.y, bus1.frame_start, bus1.busy, bus1.done}),
          32'(tbl[i].exp));
    end

    // stall at sel=2
    bus4.din = 32'h7654_3210;
    drive4(1, 1); chk4("stall_s0", 1, 0, 0, 1, 1, 0);
    drive4(0, 1); chk4("stall_s1", 1, 1, 1, 0, 1, 0);
    drive4(0, 1); chk4("stall_s2", 1, 2, 2, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      drive4(0, 0); chk4($sformatf("stall_hold%0d", k), 1, 2, 2, 0, 1, 0);
    end
    for (int s = 3; s < 8; s++) begin
      drive4(0, 1); chk4($sformatf("stall_resume%0d", s), 1, s, s, 0, 1, 0);
    end
    drive4(0, 1); chk4("stall_done", 0, 0, 0, 0, 0, 1);
    drive4(0, 1); chk4("stall_idle", 0, 0, 0, 0, 0, 0);

    // snapshot integrity: din changes mid-frame
    bus4.din = 32'hFEDC_BA98;
    drive4(1, 1); chk4("snap_s0", 1, 0, 8, 1, 1, 0);
    drive4(0, 1); chk4("snap_s1", 1, 1, 9, 0, 1, 0);
    bus4.din = 32'hFFFF_FFFF;
    for (int s = 2; s < 8; s++) begin
      drive4(0, 1); chk4($sformatf("snap_s%0d", s), 1, s, 8 + s, 0, 1, 0);
    end
    drive4(0, 1); chk4("snap_done", 0, 0, 8, 0, 0, 1);

    // back-to-back frames with start held, second frame recaptures new din
    bus4.din = 32'h7654_3210;
    for (int f = 0; f < 2; f++) begin
      for (int s = 0; s < 8; s++) begin
        if (f == 1 && s == 0) bus4.din = 32'h0123_4567;
        drive4((f == 0) || (s == 0), 1);
        chk4($sformatf("b2b_f%0d_s%0d", f, s), 1, s, (f == 0) ? s : 7 - s,
             (s == 0) ? 1 : 0, 1, 0);
      end
    end
    drive4(0, 1); chk4("b2b_done", 0, 0, 7, 0, 0, 1);

    // late start pulse at sel=3 is ignored
    bus4.din = 32'h7654_3210;
    drive4(1, 1); chk4("late_s0", 1, 0, 0, 1, 1, 0);
    for (int s = 1; s < 8; s++) begin
      drive4((s == 4), 1); chk4($sformatf("late_s%0d", s), 1, s, s, 0, 1, 0);
    end
    drive4(0, 1); chk4("late_done", 0, 0, 0, 0, 0, 1);
    drive4(0, 1); chk4("late_idle0", 0, 0, 0, 0, 0, 0);
    drive4(0, 1); chk4("late_idle1", 0, 0, 0, 0, 0, 0);

    // demux loopback with an irregular ready pattern
    dl       = 32'hA5C3_1E96;
    bus4.din = dl;
    dmx_clr  = 1'b0;
    drive4(1, 1);
    seen = 0;
    for (int c = 0; c < 40 && seen == 0; c++) begin
      drive4(0, (c % 3) != 1);
      if (bus4.done) seen = 1;
    end
    chk("loop_done_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("loop_slot%0d", i), 32'(dmx_q[i]), 32'(dl[i*4 +: 4]));
    end

    // asynchronous reset mid-frame at sel=4
    bus4.din = 32'h7654_3210;
    drive4(1, 1);
    for (int s = 1; s < 5; s++) drive4(0, 1);
    chk4("rst_pre_s4", 1, 4, 4, 0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk4("rst_async", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      drive4(0, 1); chk4($sformatf("rst_release%0d", k), 0, 0, 0, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tdm_mux_8to1.md
Name: tdm_mux_8to1

Overview:
- Time-division 8-to-1 multiplexer: the transmit end of the 1-to-8 demultiplexer path.
- On a start request it snapshots eight parallel channels.
- It then emits them one per accepted beat on a single data line, along with the 3-bit slot select a downstream 1-to-8 demultiplexer uses to route each beat back to its lane.
- A ready/valid handshake allows the consumer to stall the stream.

Parameters:
- WIDTH, 1, bit width of each channel and of the serial output y.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  8*WIDTH  parallel channels; channel i occupies din[i*WIDTH +: WIDTH].
- start  input  1  frame request; level-sampled.
- out_ready  input  1  consumer accepts the current beat.
- y  output  WIDTH  current slot data.
- sel  output  3  current slot index 0..7.
- out_valid  output  1  y and sel are valid.
- frame_start  output  1  high while the slot-0 beat is presented.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse after the slot-7 beat is accepted and no new frame follows.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low. While rst_n=0, all outputs are 0 (y=0, sel=0, out_valid=0, frame_start=0, busy=0, done=0), the snapshot register is cleared, and state is IDLE.
- Registers: all outputs are registered. y equals snapshot[sel]; no combinational path from din or start to any output.
- State IDLE:
  - out_valid=0, busy=0.
  - If start=1 at a rising edge: capture din into the snapshot, set sel=0, out_valid=1, frame_start=1, busy=1, and move to SEND.
  - Latency from start to the first valid beat is one clock.
- State SEND:
  - out_valid=1 and busy=1 throughout.
  - A beat is accepted at an edge where out_valid=1 and out_ready=1.
  - If out_ready=0, y, sel and frame_start hold their values (stall of unlimited length).
  - When a beat with sel<7 is accepted: sel increments by 1 and frame_start goes to 0.
  - When the beat with sel=7 is accepted and start=1 at that same edge: recapture din, set sel=0, set frame_start=1, and stay in SEND. Back-to-back frames therefore have no idle bubble, and done does not pulse.
  - When the beat with sel=7 is accepted and start=0: go to IDLE with out_valid=0, busy=0, sel=0, and done=1 for exactly one cycle.
- Snapshot integrity: changes on din while in SEND have no effect on the current frame. start asserted during SEND is ignored except at the slot-7 acceptance edge.
- sel never wraps mid-frame. Only the frame-boundary transition sets it back to 0.
- Reset mid-frame: asynchronous clear to the reset values above. No partial beat or done pulse follows reset release.
- After reset release, the block stays in IDLE until start is sampled high.

Test Plan:
- Reset: assert rst_n=0 mid-frame at sel=4 -> all outputs 0 immediately, without waiting for a clock edge. After release with start=0 for 5 cycles -> out_valid stays 0.
- Single frame, WIDTH=1: din=8'b1010_0110, out_ready=1, start pulsed for 1 cycle -> over 8 consecutive cycles y = 0,1,1,0,0,1,0,1 with sel=0..7 and frame_start only on sel=0. done=1 the cycle after the sel=7 beat; busy=0 afterwards.
- Stall: WIDTH=4, din channels = 4'h0..4'h7, out_ready=0 for 3 cycles at sel=2 -> y=4'h2 and sel=2 held for all 3 cycles. On resume, the remaining beats 3..7 are emitted in order with no loss or duplication.
- Snapshot: after frame capture, change din to all-ones at sel=1 -> the remaining beats still carry the captured values.
- Back-to-back: start held high continuously, out_ready=1 -> sel sequence 0..7,0..7 with no out_valid gap. frame_start is high at each sel=0, and done pulses only after start drops and the final frame ends.
- Late start: start pulsed at sel=3 and deasserted before sel=7 -> exactly one frame, done pulses, and the block returns to IDLE.
- Demux loopback: y and sel drive a 1-to-8 demultiplexer, each beat accepted -> the demultiplexer output bit for slot sel equals din[sel] for every slot.
